decimal_to_bcd_seq: RTL and testbench

DECIMAL_TO_BCD_SEQ -- requirements
Module: decimal_to_bcd_seq

---
 rtl/decimal_to_bcd_seq_pkg.sv | 15 +
 rtl/decimal_to_bcd_seq_bcd_digit_adj.sv | 18 +
 rtl/decimal_to_bcd_seq.sv | 114 +++++++++++
 tb/tb_decimal_to_bcd_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/decimal_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package decimal_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W      = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_OFFSET = 3;
    localparam int COUNT_SAT  = 300;

endpackage

// File: rtl/decimal_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import decimal_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        if (digit_in >= 4'(ADJ_THRESH)) begin
            digit_out = digit_in + 4'(ADJ_OFFSET);
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/decimal_to_bcd_seq.sv
// Iterative binary-to-BCD converter (double-dabble, one bit per cycle, MSB first)
// with valid/ready handshakes. Define DEC2BCD_COUNT_EN to add the conv_count port.
//
// state | meaning
// IDLE  | ready for a new input, no result held
// SHIFT | converting, one input bit consumed per cycle
// DONE  | result on bcd_out, waiting for out_ready
module decimal_to_bcd_seq
    import decimal_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          bin_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BCD_W*DIGITS-1:0]   bcd_out
`ifdef DEC2BCD_COUNT_EN
    ,
    output logic [8:0]                conv_count
`endif
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int ACC_W  = BCD_W * DIGITS;
    localparam int WORK_W = ACC_W + WIDTH;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic [ACC_W-1:0]   acc_adj;

    // BCD accumulator and input shift register live in one word so a single
    // left shift moves the next input bit into the units digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (work_q[WIDTH + g*BCD_W +: BCD_W]),
            .digit_out (acc_adj[g*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = {{ACC_W{1'b0}}, bin_in};
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = {acc_adj, work_q[WIDTH-1:0]} << 1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign bcd_out = work_q[WORK_W-1:WIDTH];

`ifdef DEC2BCD_COUNT_EN
    logic [8:0] conv_count_q, conv_count_d;

    always_comb begin
        conv_count_d = conv_count_q;
        if (state_q == DONE && out_ready && conv_count_q != 9'(COUNT_SAT)) begin
            conv_count_d = conv_count_q + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_count_q <= '0;
        end else begin
            conv_count_q <= conv_count_d;
        end
    end

    assign conv_count = conv_count_q;
`endif

endmodule

// File: tb/tb_decimal_to_bcd_seq.sv
// Directed bench for decimal_to_bcd_seq with hand-computed BCD results.
module tb_decimal_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] bcd_out;
`ifdef DEC2BCD_COUNT_EN
    logic [8:0]  conv_count;
`endif

    int total = 0;
    int bad   = 0;

    decimal_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out)
`ifdef DEC2BCD_COUNT_EN
        ,
        .conv_count(conv_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full conversion: accept, wait for out_valid, optionally hold in DONE, then consume.
    task automatic run_conv(input logic [31:0] val, input logic [39:0] exp_bcd,
                            input int hold, input bit noise);
        int n;
        in_valid = 1'b1;
        bin_in   = val;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 64) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                bin_in   = $urandom;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'd32);
        chk("bcd_out", 64'(bcd_out), 64'(exp_bcd));
        chk("in_ready_done", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            bin_in   = $urandom;
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_bcd", 64'(bcd_out), 64'(exp_bcd));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("in_ready_after", 64'(in_ready), 64'd1);
        chk("out_valid_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        bin_in    = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(bcd_out), 64'd0);
`ifdef DEC2BCD_COUNT_EN
        chk("rst_count", 64'(conv_count), 64'd0);
`endif
        reset = 1'b0;
        step();

        run_conv(32'd0,          40'h0000000000, 0, 1'b0);
`ifdef DEC2BCD_COUNT_EN
        chk("count_one", 64'(conv_count), 64'd1);
`endif
        run_conv(32'd12345,      40'h0000012345, 0, 1'b0);
        run_conv(32'hFFFF_FFFF,  40'h4294967295, 0, 1'b0);
        run_conv(32'd9,          40'h0000000009, 0, 1'b0);
        run_conv(32'd10,         40'h0000000010, 0, 1'b0);
        run_conv(32'd1000000000, 40'h1000000000, 10, 1'b0);
        run_conv(32'd4000000000, 40'h4000000000, 0, 1'b1);
        run_conv(32'd12345,      40'h0000012345, 2, 1'b1);

        // Abort mid-conversion.
        in_valid = 1'b1;
        bin_in   = 32'd5555;
        step();
        in_valid = 1'b0;
        repeat (15) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_bcd", 64'(bcd_out), 64'd0);
`ifdef DEC2BCD_COUNT_EN
        chk("abort_count", 64'(conv_count), 64'd0);
`endif
        run_conv(32'd99, 40'h0000000099, 0, 1'b0);

`ifdef DEC2BCD_COUNT_EN
        for (int k = 0; k < 305; k++) begin
            run_conv(32'd7, 40'h0000000007, 0, 1'b0);
        end
        chk("count_sat", 64'(conv_count), 64'd300);
        run_conv(32'd8, 40'h0000000008, 0, 1'b0);
        chk("count_sat_hold", 64'(conv_count), 64'd300);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
